// File: rtl/nemesis_rom_slot.sv
// Single-entry cached ROM read slot: turns a level cs/addr ROM request into an
// SDRAM req/ack/dst transaction and holds the last fetched 16-bit word.
module nemesis_rom_slot #(
  parameter int          AW     = 17,
  parameter int          DW     = 16,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cen,
  input  logic          i_cs,
  input  logic [AW-1:0] i_addr,
  output logic          o_ok,
  output logic [DW-1:0] o_data,
  input  logic          i_flush,
  output logic          o_req,
  output logic [21:0]   o_req_addr,
  input  logic          i_ack,
  input  logic          i_dst,
  input  logic [15:0]   i_sdram_data,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_valid, w_valid_nxt;
  logic [21:0] r_tag, w_tag_nxt;
  logic [15:0] r_data, w_data_nxt;
  logic        r_req, w_req_nxt;
  logic [21:0] r_req_addr, w_req_addr_nxt;
  logic        r_discard, w_discard_nxt;
  logic [21:0] w_waddr;
  logic        w_hit;

  // Byte-addressed 8-bit instances fetch the containing 16-bit word.
  generate
    if (DW == 8) begin : g_waddr8
      assign w_waddr = 22'(i_addr >> 1);
    end else begin : g_waddr16
      assign w_waddr = 22'(i_addr);
    end
  endgenerate

  assign w_hit = i_cs && r_valid && (w_waddr == r_tag) && (r_state == IDLE);

  // SDRAM handshake: o_req rises with o_req_addr stable and both hold until the
  // cycle i_ack is sampled high; i_dst later marks the one cycle i_sdram_data is valid.
  always_comb begin
    w_state_nxt    = r_state;
    w_valid_nxt    = r_valid;
    w_tag_nxt      = r_tag;
    w_data_nxt     = r_data;
    w_req_nxt      = r_req;
    w_req_addr_nxt = r_req_addr;
    w_discard_nxt  = r_discard;
    case (r_state)
      IDLE: begin
        if (i_cs && !w_hit) begin
          w_state_nxt    = REQ;
          w_tag_nxt      = w_waddr;
          w_req_nxt      = 1'b1;
          w_req_addr_nxt = OFFSET + w_waddr;
          w_valid_nxt    = 1'b0;
          w_discard_nxt  = 1'b0;
        end
      end
      REQ: begin
        if (i_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = WAIT;
          if (i_dst) begin
            w_data_nxt  = i_sdram_data;
            w_valid_nxt = !(r_discard || i_flush);
            w_state_nxt = IDLE;
          end
        end
      end
      WAIT: begin
        if (i_dst) begin
          w_data_nxt  = i_sdram_data;
          w_valid_nxt = !(r_discard || i_flush);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A flush mid-transaction lets the SDRAM side finish but poisons the fill.
    if (i_flush) begin
      w_valid_nxt = 1'b0;
      if (r_state != IDLE) w_discard_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_valid    <= 1'b0;
      r_tag      <= '0;
      r_data     <= '0;
      r_req      <= 1'b0;
      r_req_addr <= '0;
      r_discard  <= 1'b0;
    end else if (i_cen) begin
      r_state    <= w_state_nxt;
      r_valid    <= w_valid_nxt;
      r_tag      <= w_tag_nxt;
      r_data     <= w_data_nxt;
      r_req      <= w_req_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_discard  <= w_discard_nxt;
    end
  end

  generate
    if (DW == 8) begin : g_data8
      assign o_data = i_addr[0] ? r_data[15:8] : r_data[7:0];
    end else begin : g_data16
      assign o_data = r_data[DW-1:0];
    end
  endgenerate

  assign o_ok        = w_hit;
  assign o_req       = r_req;
  assign o_req_addr  = r_req_addr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nemesis_rom_slot.sv
// Bench for nemesis_rom_slot: a DW=16 main-ROM slot and a DW=8 sound-ROM slot
// sharing clock, reset and the SDRAM-side strobes.
module tb_nemesis_rom_slot;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cen = 1'b1, flush = 1'b0, ack = 1'b0, dst = 1'b0;
  logic [15:0] sd_data = '0;

  logic        cs16 = 1'b0;
  logic [16:0] addr16 = '0;
  logic        ok16, req16;
  logic [15:0] data16;
  logic [21:0] req_addr16;
  logic [1:0]  st16;

  logic        cs8 = 1'b0;
  logic [13:0] addr8 = '0;
  logic        ok8, req8;
  logic [7:0]  data8;
  logic [21:0] req_addr8;
  logic [1:0]  st8;

  nemesis_rom_slot #(.AW(17), .DW(16), .OFFSET(22'h10000)) u16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cen(cen), .i_cs(cs16), .i_addr(addr16),
    .o_ok(ok16), .o_data(data16), .i_flush(flush), .o_req(req16),
    .o_req_addr(req_addr16), .i_ack(ack), .i_dst(dst), .i_sdram_data(sd_data),
    .o_dbg_state(st16)
  );

  nemesis_rom_slot #(.AW(14), .DW(8), .OFFSET(22'h0)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cen(cen), .i_cs(cs8), .i_addr(addr8),
    .o_ok(ok8), .o_data(data8), .i_flush(flush), .o_req(req8),
    .o_req_addr(req_addr8), .i_ack(ack), .i_dst(dst), .i_sdram_data(sd_data),
    .o_dbg_state(st8)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [21:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic wait_req(input bit sel8, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = sel8 ? req8 : req16;
    end
    chk({name, "_req_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic fill(input logic [15:0] d);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    dst = 1'b1;
    sd_data = d;
    @(negedge clk);
    dst = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [16:0] addr;
    logic [15:0] sd;
    bit          miss;
    logic [21:0] req_addr;
    logic [15:0] data;
    int          gap;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] e;

    vecs[0] = '{17'h00123,  16'hBEEF, 1'b1, 22'h10123, 16'hBEEF, 3};
    vecs[1] = '{17'h00123,  16'h0000, 1'b0, 22'h0,     16'hBEEF, 1};
    vecs[2] = '{17'h1FFFF,  16'h1234, 1'b1, 22'h2FFFF, 16'h1234, 1};
    vecs[3] = '{17'h00000,  16'h0F0F, 1'b1, 22'h10000, 16'h0F0F, 1};
    vecs[4] = '{17'h00000,  16'h0000, 1'b0, 22'h0,     16'h0F0F, 1};
    vecs[5] = '{17'h1FFFF,  16'h4321, 1'b1, 22'h2FFFF, 16'h4321, 1};

    // reset state
    #12;
    chk("rst_ok16", 32'(ok16), 32'd0);
    chk("rst_data16", 32'(data16), 32'd0);
    chk("rst_req16", 32'(req16), 32'd0);
    chk("rst_req_addr16", 32'(req_addr16), 32'd0);
    chk("rst_state16", 32'(st16), 32'd0);
    chk("rst_data8", 32'(data8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // DW=8 slot: byte lanes of one fetched word
    @(negedge clk);
    cs8 = 1'b1;
    addr8 = 14'h0041;
    #1;
    chk("b8_miss_ok", 32'(ok8), 32'd0);
    wait_req(1'b1, "b8");
    chk("b8_req_addr", 32'(req_addr8), 32'h20);
    fill(16'hA55A);
    chk("b8_ok41", 32'(ok8), 32'd1);
    chk("b8_data41", 32'(data8), 32'hA5);
    @(negedge clk);
    addr8 = 14'h0040;
    #1;
    chk("b8_ok40", 32'(ok8), 32'd1);
    chk("b8_data40", 32'(data8), 32'h5A);
    @(negedge clk);
    #1;
    chk("b8_no_req", 32'(req8), 32'd0);
    cs8 = 1'b0;

    // table-driven reads on the DW=16 slot
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cs16 = 1'b1;
      addr16 = vecs[i].addr;
      #1;
      if (vecs[i].miss) begin
        exp_q.push_back(vecs[i].req_addr);
        exp_q.push_back(22'(vecs[i].data));
        chk($sformatf("v%0d_miss_ok", i), 32'(ok16), 32'd0);
        wait_req(1'b0, $sformatf("v%0d", i));
        e = exp_q.pop_front();
        chk($sformatf("v%0d_req_addr", i), 32'(req_addr16), 32'(e));
        fill(vecs[i].sd);
      end else begin
        exp_q.push_back(22'(vecs[i].data));
      end
      e = exp_q.pop_front();
      chk($sformatf("v%0d_ok", i), 32'(ok16), 32'd1);
      chk($sformatf("v%0d_data", i), 32'(data16), 32'(e[15:0]));
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_no_req", i), 32'(req16), 32'd0);
      cs16 = 1'b0;
      repeat (vecs[i].gap) @(negedge clk);
    end

    // address change while waiting for data
    @(negedge clk);
    cs16 = 1'b1;
    addr16 = 17'h10;
    wait_req(1'b0, "chg");
    chk("chg_req_addr1", 32'(req_addr16), 32'h10010);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #1;
    addr16 = 17'h20;
    chk("chg_ok_wait", 32'(ok16), 32'd0);
    @(negedge clk);
    dst = 1'b1;
    sd_data = 16'h1111;
    @(negedge clk);
    dst = 1'b0;
    #1;
    chk("chg_ok_after_fill", 32'(ok16), 32'd0);
    wait_req(1'b0, "chg2");
    chk("chg_req_addr2", 32'(req_addr16), 32'h10020);
    fill(16'h2222);
    chk("chg_ok", 32'(ok16), 32'd1);
    chk("chg_data", 32'(data16), 32'h2222);
    cs16 = 1'b0;

    // flush during WAIT discards the fill and re-requests
    @(negedge clk);
    cs16 = 1'b1;
    addr16 = 17'h55;
    wait_req(1'b0, "fl");
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    dst = 1'b1;
    sd_data = 16'h3333;
    @(negedge clk);
    dst = 1'b0;
    #1;
    chk("fl_ok_discard", 32'(ok16), 32'd0);
    wait_req(1'b0, "fl2");
    chk("fl_req_addr2", 32'(req_addr16), 32'h10055);
    fill(16'h4444);
    chk("fl_ok", 32'(ok16), 32'd1);
    chk("fl_data", 32'(data16), 32'h4444);

    // asynchronous reset while in REQ
    @(negedge clk);
    addr16 = 17'h77;
    wait_req(1'b0, "ar");
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req_drop", 32'(req16), 32'd0);
    chk("ar_req_addr", 32'(req_addr16), 32'd0);
    chk("ar_state", 32'(st16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_ok_after", 32'(ok16), 32'd0);
    wait_req(1'b0, "ar2");
    chk("ar_req_addr2", 32'(req_addr16), 32'h10077);
    fill(16'h6666);
    chk("ar_data", 32'(data16), 32'h6666);

    // i_cen low freezes REQ; then ack and dst in the same cycle
    @(negedge clk);
    addr16 = 17'h99;
    wait_req(1'b0, "ad");
    cen = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    cen = 1'b1;
    ack = 1'b0;
    #1;
    chk("cen_hold_req", 32'(req16), 32'd1);
    chk("cen_hold_state", 32'(st16), 32'd1);
    ack = 1'b1;
    dst = 1'b1;
    sd_data = 16'h5555;
    @(negedge clk);
    ack = 1'b0;
    dst = 1'b0;
    #1;
    chk("ad_ok", 32'(ok16), 32'd1);
    chk("ad_data", 32'(data16), 32'h5555);
    chk("ad_no_req", 32'(req16), 32'd0);

    // flush and dst in the same cycle: flush wins
    @(negedge clk);
    addr16 = 17'hAA;
    wait_req(1'b0, "fd");
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    dst = 1'b1;
    flush = 1'b1;
    sd_data = 16'h7777;
    @(negedge clk);
    dst = 1'b0;
    flush = 1'b0;
    #1;
    chk("fd_ok", 32'(ok16), 32'd0);
    wait_req(1'b0, "fd2");
    chk("fd_req_addr2", 32'(req_addr16), 32'h100AA);
    cs16 = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nemesis_rom_slot.md
Name: nemesis_rom_slot

Overview:
- Single-entry cached ROM read slot between a CPU-side ROM request and the SDRAM controller port.
- Sits directly downstream of the debug mux: it consumes that mux's sdram cs/addr outputs and returns ok/data to it.
- Converts a level-sensitive cs/addr request into a req/ack/data-strobe transaction toward SDRAM.
- One instance for the Z80 sound ROM (DW=8) and one for the 68k main ROM (DW=16).

Parameters:
- AW, 17, CPU-side address width: byte address when DW=8, word address when DW=16.
- DW, 16, data width; legal values 8 or 16 only.
- OFFSET, 22'h0, SDRAM word base address added to every request.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cen  in  1  clock enable; all state advances only when high
- i_cs  in  1  ROM request, level, held until o_ok
- i_addr  in  AW  request address
- o_ok  out  1  data valid for current i_addr
- o_data  out  DW  read data
- i_flush  in  1  invalidate cached entry (ROM download / reset of core)
- o_req  out  1  SDRAM request, held until i_ack
- o_req_addr  out  22  SDRAM word address
- i_ack  in  1  SDRAM accepted request (1-cycle pulse)
- i_dst  in  1  SDRAM data strobe (1-cycle pulse, data valid)
- i_sdram_data  in  16  SDRAM read word

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, valid=0, tag=0, data=0, o_req=0, o_req_addr=0. o_ok=0 and o_data=0 follow from the cleared state.
- Word address: DW=16 gives waddr=i_addr. DW=8 gives waddr=i_addr>>1.
- o_req_addr=OFFSET+waddr. Sum truncated to 22 bits; wrap is silent.
- Hit definition: hit = i_cs & valid & (waddr==tag) & state==IDLE.
- o_ok=hit, combinational. The hit path has zero-cycle latency.
- o_data is driven from the stored 16-bit word:
  - DW=16: the whole word.
  - DW=8: i_addr[0]=0 selects bits [7:0]; i_addr[0]=1 selects bits [15:8].
  - o_data is valid whenever o_ok=1.
- All state transitions occur on an i_clk edge with i_cen=1.
- FSM states IDLE, REQ, WAIT:
  - IDLE, i_cs=1, not hit: latch tag=waddr, set o_req=1, go to REQ.
  - REQ: o_req held high, o_req_addr frozen to OFFSET+tag. On i_ack, clear o_req and go to WAIT.
  - WAIT: on i_dst, store data=i_sdram_data, set valid=1, go to IDLE.
  - The first o_ok of a miss is therefore the cycle after i_dst, provided i_addr still matches.
- i_ack and i_dst in the same cycle while in REQ: treat as both. Store data, set valid=1, clear o_req, go to IDLE.
- i_dst received in IDLE or REQ without a prior i_ack: ignored.
- i_cs dropped or i_addr changed during REQ or WAIT:
  - The outstanding transaction completes and the cache fills with the old tag.
  - o_ok stays 0 until the FSM is back in IDLE.
  - A mismatching address then misses and starts a new request.
- Cache entry:
  - valid=0 during REQ and WAIT, so a stale hit on the old entry is never reported.
  - The entry is overwritten only on i_dst.
- i_flush=1 (sampled with i_cen):
  - valid cleared.
  - An outstanding transaction completes on the SDRAM side (o_req still waits for i_ack).
  - The returned data is discarded: valid stays 0.
  - The FSM returns to IDLE and re-requests if i_cs is still high.
- i_flush and i_dst in the same cycle: flush wins, valid=0.
- i_cen=0: the FSM and all registers hold. o_ok may still assert combinationally on a hit.
- Asynchronous reset mid-transaction:
  - Everything returns to reset values immediately and o_req drops.
  - The SDRAM side must tolerate the abandoned request.

Test Plan:
- Reset, then DW=16, OFFSET=22'h10000, i_cs=1, i_addr=17'h00123 → o_req=1 with o_req_addr=22'h10123. After i_ack then i_dst with data 16'hBEEF: o_ok=1 and o_data=16'hBEEF the next cycle, with no further o_req.
- Hit path: after the fill above, drop i_cs for 3 cycles, then reassert at the same address → o_ok=1 in the same cycle, o_req stays 0.
- DW=8, OFFSET=0, fill address 14'h0041 with i_sdram_data=16'hA55A:
  - o_req_addr=22'h20.
  - o_data=8'hA5 for address 41, then 8'h5A for address 40 with no new request.
- Address change during WAIT: request 17'h10, switch to 17'h20 before i_dst.
  - Transaction 17'h10 completes and o_ok stays 0.
  - A second request with o_req_addr=OFFSET+17'h20 follows.
  - The second fill yields o_ok=1.
- i_flush asserted during WAIT → after i_dst, valid=0 and o_ok=0. A re-request of the same address is issued while i_cs stays high.
- Asynchronous reset:
  - Pull i_rst_n low between clock edges while in REQ → o_req drops immediately, without waiting for an edge.
  - After release, the same address misses and a fresh request is issued.
  - Separately, i_ack and i_dst in the same cycle → single-cycle completion and o_ok the next cycle.
